// File: rtl/stopwatch_bcd_counter_pkg.sv
// Shared types and digit limits for the stopwatch BCD counter.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAP  = 2'd2
  } stopwatch_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t UNITS_MAX     = 4'd9;
  localparam bcd_digit_t TENS_MAX      = 4'd5;
  localparam bcd_digit_t HOUR_TENS_MAX = 4'd2;

endpackage

// File: rtl/stopwatch_bcd_counter_digit.sv
// Single BCD digit with wrap at MAX; an illegal value (>MAX) wraps to 0 on the next increment.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter bcd_digit_t MAX = UNITS_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       clear,
  output bcd_digit_t value,
  output bcd_digit_t value_next,
  output logic       carry
);

  always_comb begin
    carry      = enable && (value >= MAX);
    value_next = value;
    if (clear) begin
      value_next = '0;
    end else if (enable) begin
      value_next = (value >= MAX) ? bcd_digit_t'(0) : value + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) value <= '0;
    else     value <= value_next;
  end

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// BCD hh:mm:ss stopwatch driven by a 1 Hz tick, with start/stop, lap freeze and clear.
module stopwatch_bcd_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned HOUR_WRAP = 24
) (
  input  logic       CLOCK_50_I,
  input  logic       RESET_I,
  input  logic       TICK_I,
  input  logic       START_STOP_I,
  input  logic       LAP_I,
  input  logic       CLEAR_I,
  output logic [7:0] SEC_BCD_O,
  output logic [7:0] MIN_BCD_O,
  output logic [7:0] HOUR_BCD_O,
  output logic       RUNNING_O,
  output logic       LAP_O,
  output logic       ROLLOVER_O
);

  localparam bcd_digit_t WRAP_TENS  = bcd_digit_t'((HOUR_WRAP - 1) / 10);
  localparam bcd_digit_t WRAP_UNITS = bcd_digit_t'((HOUR_WRAP - 1) % 10);

  stopwatch_state_t state, state_next;
  logic             snap_load;
  logic             count_en;
  logic             su_carry, st_carry, mu_carry, mt_carry;
  bcd_digit_t       su, st, mu, mt, su_n, st_n, mu_n, mt_n;
  bcd_digit_t       h_tens, h_units, h_tens_n, h_units_n;
  logic             hour_wrap;
  logic [23:0]      snapshot;
  logic [23:0]      live;
  logic [23:0]      live_next;

  always_comb begin
    state_next = state;
    snap_load  = 1'b0;
    if (CLEAR_I) begin
      state_next = S_IDLE;
    end else if (START_STOP_I) begin
      state_next = (state == S_IDLE) ? S_RUN : S_IDLE;
    end else if (LAP_I) begin
      case (state)
        S_RUN: begin
          state_next = S_LAP;
          snap_load  = 1'b1;
        end
        S_LAP:   state_next = S_RUN;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
    if (RESET_I) state <= S_IDLE;
    else         state <= state_next;
  end

  // Uses the pre-edge state, so a stopping tick counts and a starting tick does not.
  assign count_en = TICK_I && (state != S_IDLE) && !CLEAR_I;

  bcd_digit_counter #(.MAX(UNITS_MAX)) u_sec_units (
    .clk(CLOCK_50_I), .rst(RESET_I), .enable(count_en), .clear(CLEAR_I),
    .value(su), .value_next(su_n), .carry(su_carry));
  bcd_digit_counter #(.MAX(TENS_MAX)) u_sec_tens (
    .clk(CLOCK_50_I), .rst(RESET_I), .enable(su_carry), .clear(CLEAR_I),
    .value(st), .value_next(st_n), .carry(st_carry));
  bcd_digit_counter #(.MAX(UNITS_MAX)) u_min_units (
    .clk(CLOCK_50_I), .rst(RESET_I), .enable(st_carry), .clear(CLEAR_I),
    .value(mu), .value_next(mu_n), .carry(mu_carry));
  bcd_digit_counter #(.MAX(TENS_MAX)) u_min_tens (
    .clk(CLOCK_50_I), .rst(RESET_I), .enable(mu_carry), .clear(CLEAR_I),
    .value(mt), .value_next(mt_n), .carry(mt_carry));

  always_comb begin
    hour_wrap = mt_carry && (h_tens == WRAP_TENS) && (h_units == WRAP_UNITS);
    h_tens_n  = h_tens;
    h_units_n = h_units;
    if (CLEAR_I || hour_wrap) begin
      h_tens_n  = '0;
      h_units_n = '0;
    end else if (mt_carry) begin
      if (h_units >= UNITS_MAX) begin
        h_units_n = '0;
        h_tens_n  = (h_tens >= HOUR_TENS_MAX) ? bcd_digit_t'(0) : h_tens + 4'd1;
      end else begin
        h_units_n = h_units + 4'd1;
      end
    end
  end

  assign live      = {h_tens, h_units, mt, mu, st, su};
  assign live_next = {h_tens_n, h_units_n, mt_n, mu_n, st_n, su_n};

  always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
    if (RESET_I) begin
      h_tens     <= '0;
      h_units    <= '0;
      snapshot   <= '0;
      ROLLOVER_O <= 1'b0;
    end else begin
      h_tens     <= h_tens_n;
      h_units    <= h_units_n;
      ROLLOVER_O <= hour_wrap;
      if (CLEAR_I)        snapshot <= '0;
      else if (snap_load) snapshot <= live_next;
    end
  end

  assign RUNNING_O = (state == S_RUN) || (state == S_LAP);
  assign LAP_O     = (state == S_LAP);
  assign {HOUR_BCD_O, MIN_BCD_O, SEC_BCD_O} = LAP_O ? snapshot : live;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Bench for stopwatch_bcd_counter: two instances (24 h and 12 h wrap) against a seconds-count model.
module tb_stopwatch_bcd_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0, ss = 1'b0, lap = 1'b0, clr = 1'b0;
  logic [7:0] sec0, min0, hour0, sec1, min1, hour1;
  logic       run0, lap0, roll0, run1, lap1, roll1;

  int total = 0;
  int bad   = 0;

  int   mcnt[2];
  int   msnap[2];
  int   mmode[2];   // 0 stopped, 1 running, 2 running with frozen display
  logic mroll[2];
  int   period[2] = '{86400, 43200};

  always #10 clk = ~clk;

  stopwatch_bcd_counter #(.HOUR_WRAP(24)) u_dut24 (
    .CLOCK_50_I(clk), .RESET_I(rst), .TICK_I(tick), .START_STOP_I(ss),
    .LAP_I(lap), .CLEAR_I(clr), .SEC_BCD_O(sec0), .MIN_BCD_O(min0),
    .HOUR_BCD_O(hour0), .RUNNING_O(run0), .LAP_O(lap0), .ROLLOVER_O(roll0));

  stopwatch_bcd_counter #(.HOUR_WRAP(12)) u_dut12 (
    .CLOCK_50_I(clk), .RESET_I(rst), .TICK_I(tick), .START_STOP_I(ss),
    .LAP_I(lap), .CLEAR_I(clr), .SEC_BCD_O(sec1), .MIN_BCD_O(min1),
    .HOUR_BCD_O(hour1), .RUNNING_O(run1), .LAP_O(lap1), .ROLLOVER_O(roll1));

  function automatic logic [23:0] to_bcd(int s);
    int h, m, x;
    h = s / 3600;
    m = (s / 60) % 60;
    x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int shown(int d);
    return (mmode[d] == 2) ? msnap[d] : mcnt[d];
  endfunction

  task automatic check_all();
    logic [2:0] f0, f1;
    f0 = {mmode[0] != 0, mmode[0] == 2, mroll[0]};
    f1 = {mmode[1] != 0, mmode[1] == 2, mroll[1]};
    check("disp24",  {hour0, min0, sec0}, to_bcd(shown(0)));
    check("flags24", {run0, lap0, roll0}, f0);
    check("disp12",  {hour1, min1, sec1}, to_bcd(shown(1)));
    check("flags12", {run1, lap1, roll1}, f1);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mcnt[d] = 0; msnap[d] = 0; mmode[d] = 0; mroll[d] = 1'b0;
    end
  endtask

  task automatic model_step(logic t, logic s, logic l, logic c);
    for (int d = 0; d < 2; d++) begin
      bit counting;
      int nc;
      counting = (mmode[d] != 0) && t && !c;
      nc       = counting ? (mcnt[d] + 1) % period[d] : mcnt[d];
      mroll[d] = counting && (nc == 0);
      if (c) begin
        mcnt[d] = 0; msnap[d] = 0; mmode[d] = 0;
      end else begin
        mcnt[d] = nc;
        if (s) mmode[d] = (mmode[d] == 0) ? 1 : 0;
        else if (l) begin
          if (mmode[d] == 1) begin
            mmode[d] = 2;
            msnap[d] = nc;
          end else if (mmode[d] == 2) begin
            mmode[d] = 1;
          end
        end
      end
    end
  endtask

  task automatic cyc(logic t, logic s, logic l, logic c);
    tick = t; ss = s; lap = l; clr = c;
    @(posedge clk);
    #1;
    tick = 1'b0; ss = 1'b0; lap = 1'b0; clr = 1'b0;
    model_step(t, s, l, c);
    check_all();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    cyc(0, 0, 0, 0);

    // Basic count
    cyc(0, 1, 0, 0);
    repeat (61) cyc(1, 0, 0, 0);
    check("basic_mmss", {min0, sec0}, 16'h0101);
    check("basic_run", run0, 1'b1);

    // Asynchronous reset mid-count
    repeat (3) cyc(1, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    check("reset_disp", {hour0, min0, sec0}, 24'h0);
    #2 rst = 1'b0;
    cyc(0, 0, 0, 0);
    check("reset_hold", {hour0, min0, sec0}, 24'h0);

    // Lap freeze and release
    cyc(0, 1, 0, 0);
    repeat (10) cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    repeat (5) cyc(1, 0, 0, 0);
    check("lap_frozen", sec0, 8'h10);
    check("lap_flag", lap0, 1'b1);
    cyc(0, 0, 1, 0);
    check("lap_release", sec0, 8'h15);

    // Coincident events
    cyc(1, 1, 0, 0);
    check("stop_tick", {sec0, run0}, {8'h16, 1'b0});
    cyc(1, 1, 0, 0);
    check("start_tick", {sec0, run0}, {8'h16, 1'b1});
    cyc(1, 0, 1, 1);
    check("clear_all", {hour0, min0, sec0, run0, lap0}, 26'h0);

    // Stopped behaviour
    repeat (10) cyc(1, 0, 0, 0);
    check("idle_ticks", sec0, 8'h00);
    cyc(0, 0, 1, 0);
    check("idle_lap", lap0, 1'b0);

    // Rollover of the 12 h instance, taken while the display is frozen
    cyc(0, 1, 0, 0);
    repeat (43199) cyc(1, 0, 0, 0);
    check("pre_wrap12", {hour1, min1, sec1}, 24'h115959);
    check("pre_wrap24", {hour0, min0, sec0}, 24'h115959);
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    check("roll12_pulse", roll1, 1'b1);
    check("roll12_frozen", {hour1, min1, sec1}, 24'h115959);
    check("roll24_quiet", roll0, 1'b0);
    cyc(0, 0, 1, 0);
    check("roll12_end", roll1, 1'b0);
    check("wrap12_disp", {hour1, min1, sec1}, 24'h000000);
    check("wrap24_disp", {hour0, min0, sec0}, 24'h120000);

    // Randomized control traffic
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      cyc(logic'($urandom_range(0, 1)),
          logic'($urandom_range(0, 15) == 0),
          logic'($urandom_range(0, 7) == 0),
          logic'($urandom_range(0, 63) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_bcd_counter.md
# stopwatch_bcd_counter

Time-of-day/stopwatch counter that sits directly downstream of the 1 Hz tick generator. It consumes the one-cycle-per-second enable pulse and keeps a BCD hours:minutes:seconds count. It supports start/stop, lap (display freeze) and clear controls, and presents BCD digits ready for the hex-to-seven-segment converters.

## Interface
- `HOUR_WRAP`, default 24: hour count wraps from `HOUR_WRAP-1` to 0. Legal range 1..24.
- `CLOCK_50_I`  in  1  50 MHz system clock; all logic on its rising edge.
- `RESET_I`  in  1  reset, asynchronous and active-high.
- `TICK_I`  in  1  one-cycle pulse, once per second, from the tick generator.
- `START_STOP_I`  in  1  one-cycle pulse; toggles counting.
- `LAP_I`  in  1  one-cycle pulse; freezes or releases the display.
- `CLEAR_I`  in  1  one-cycle pulse; zeroes the count and stops the counter.
- `SEC_BCD_O`  out  8  displayed seconds; [7:4] tens 0–5, [3:0] units 0–9.
- `MIN_BCD_O`  out  8  displayed minutes; same format as seconds.
- `HOUR_BCD_O`  out  8  displayed hours; [7:4] tens 0–2, [3:0] units 0–9.
- `RUNNING_O`  out  1  high in RUN and LAP.
- `LAP_O`  out  1  high in LAP (display frozen).
- `ROLLOVER_O`  out  1  one-cycle pulse when the live count wraps to 00:00:00.

## Operation
- **States:** IDLE, RUN, LAP. Reset state is IDLE.
- **Reset values:** all count, snapshot and output registers are 0. RUNNING_O, LAP_O and ROLLOVER_O are 0.
- **Live count:** registered BCD seconds, minutes and hours.
- **Incrementing:** the live count increments only when TICK_I=1 and the current state is RUN or LAP.
- **Digit rules:**
  - Seconds units wrap 9→0 and carry into seconds tens.
  - Seconds tens wrap 5→0 and carry into minutes. Minutes follow the same rules.
  - Hours wrap when the value equals `HOUR_WRAP-1`.
  - 23:59:59 plus a tick gives 00:00:00 and ROLLOVER_O=1.
- **State transitions:**
  - IDLE + START_STOP_I → RUN.
  - RUN + START_STOP_I → IDLE.
  - RUN + LAP_I → LAP; the snapshot loads the live count, including a tick counted in the same cycle.
  - LAP + LAP_I → RUN (display released).
  - LAP + START_STOP_I → IDLE (counting stops, display released).
  - LAP_I in IDLE is ignored.
- **Display mux:** outputs show the snapshot in LAP and the live count otherwise. This is a combinational mux of registers.
- **Simultaneous-event priority:** CLEAR_I > START_STOP_I > LAP_I.
- **CLEAR_I:** in any state, zeroes the live count and snapshot and forces IDLE. A coincident TICK_I is discarded.
- **Tick at a state boundary:**
  - A tick coincident with a START_STOP_I that stops the counter (RUN→IDLE) is counted.
  - A tick coincident with a START_STOP_I that starts it (IDLE→RUN) is not counted.
  - The decision follows the state before the edge.
- **Illegal BCD digits (≥10, or tens above limit):** the next increment forces that digit to 0 and generates a carry. There is no other recovery.
- **Reset mid-operation:** all registers clear immediately (asynchronously). Any partially completed carry is dropped.

## Timing
- Latency is 1 cycle: a TICK_I sampled at edge n updates the outputs after edge n.
- Control pulses also take effect after the same edge; RUNNING_O and LAP_O are registered state decodes.
- ROLLOVER_O is registered and high for exactly the one cycle in which the live count first reads 00:00:00 after a wrap.
- ROLLOVER_O still pulses in LAP even though the display is frozen.
- A carry ripples through all six digits within one cycle.
- Inputs are assumed to be one-cycle pulses. A level held high on START_STOP_I or LAP_I toggles the state every cycle; this is not filtered.

## Structure
- **Package `stopwatch_pkg`:**
  - state enum `stopwatch_state_t` {S_IDLE, S_RUN, S_LAP};
  - digit limit constants: units 9, seconds/minutes tens 5;
  - BCD digit typedef (`logic [3:0]`).
- **Sub-module `bcd_digit_counter`:**
  - one BCD digit with parameter MAX and inputs enable and clear;
  - outputs the digit value and a carry (enable && value==MAX).
  - Four instances cover the seconds and minutes digits.
  - Hours use dedicated logic for the two-digit `HOUR_WRAP` compare.

## Test plan
- **Reset:** assert RESET_I mid-count → all outputs 0, state IDLE, next cycle without TICK_I still 00:00:00.
- **Basic count:** START_STOP_I pulse, then 61 ticks → MIN_BCD_O=8'h01, SEC_BCD_O=8'h01, RUNNING_O=1.
- **Rollover:** preload via 86399 ticks (accelerated tick), then 1 tick → 00:00:00 with a one-cycle ROLLOVER_O. With `HOUR_WRAP`=12, the wrap occurs after 11:59:59.
- **Lap:** at 00:00:10 pulse LAP_I, then 5 ticks → display holds 8'h10 and LAP_O=1. Pulse LAP_I again → display shows 00:00:15.
- **Coincidences:**
  - TICK_I with START_STOP_I in RUN → count +1, then IDLE.
  - TICK_I with START_STOP_I in IDLE → count unchanged, then RUN.
  - CLEAR_I with TICK_I and LAP_I → 00:00:00, IDLE.
- **Stopped:** in IDLE, 10 ticks → count unchanged. LAP_I in IDLE → LAP_O stays 0.
